// File: rtl/dmem_responder.sv
// dmem_responder: 1024x64 data memory behind valid/ready request and response channels, fixed access latency; define DMEM_ERR_EN to drive resp_err on out-of-range accesses
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int WIDTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [63:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t           state_q;
  logic [3:0]       cnt_q;
  logic             wr_q;
  logic             in_range_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             access;
  logic [WIDTH-1:0] mem [DEPTH];
  assign access     = (state_q == WAIT) && (cnt_q == '0);
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  // Array is deliberately outside reset; a reset before the access edge leaves state_q out of WAIT, so no write lands
  always_ff @(posedge clk)
    if (access && wr_q && in_range_q) mem[addr_q] <= wdata_q;
  // Transaction sequencer: capture at acceptance, count down, access, hold response until taken
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      in_range_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            wr_q        <= req_write;
            in_range_q  <= req_addr < 64'(DEPTH);
            addr_q      <= req_addr[AW-1:0];
            wdata_q     <= req_wdata;
            cnt_q       <= 4'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT:
          if (cnt_q == '0) begin
            rdata_q      <= (!wr_q && in_range_q) ? mem[addr_q] : '0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else cnt_q <= cnt_q - 4'd1;
        RESP:
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
`ifdef DMEM_ERR_EN
  logic err_q;
  // Out-of-range flag changes only at the access edge so it stays stable through the response
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else if (access) err_q <= ~in_range_q;
  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif
endmodule
